// File: rtl/shifter_pkg.sv
// Shared constants, state encoding and round-robin pick helper for shifter_arbiter.
// Pure declarations; no timing or backpressure of its own.
package shifter_pkg;

  localparam int SH_DW   = 16;
  localparam int SH_AW   = 4;
  localparam int RR_MAXN = 8;
  localparam int RR_IW   = 3;

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic             found;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // Scan from ptr upward, wrapping mod n; lowest offset wins, so iterate downward.
  function automatic rr_pick_t rr_pick(input logic [RR_MAXN-1:0] valid,
                                       input logic [RR_IW-1:0]   ptr,
                                       input int                 n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = RR_MAXN - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = RR_IW'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_leftshifter_16bit.sv
// 16-bit logical left barrel shifter, zero fill, four binary-weighted stages.
// Latency: combinational. Backpressure: none.
// No handshake; caller registers the result.
module barrel_leftshifter_16bit (
  input  logic [15:0] in,
  input  logic [3:0]  ctrl,
  output logic [15:0] out
);

  logic [15:0] w_s1;
  logic [15:0] w_s2;
  logic [15:0] w_s4;

  assign w_s1 = ctrl[0] ? {in[14:0],   1'b0}  : in;
  assign w_s2 = ctrl[1] ? {w_s1[13:0], 2'b0}  : w_s1;
  assign w_s4 = ctrl[2] ? {w_s2[11:0], 4'b0}  : w_s2;
  assign out  = ctrl[3] ? {w_s4[7:0],  8'b0}  : w_s4;

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin share of one barrel left shifter among NREQ requesters; optional SHARB_STATS_EN grant counters.
// Latency: 1 cycle accept-to-out_valid, 1 result/cycle sustained.
// Backpressure: result held while out_ready=0; req_ready drops to 0 until the slot can drain.
module shifter_arbiter
  import shifter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*SH_DW-1:0] req_data,
  input  logic [NREQ*SH_AW-1:0] req_amt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SH_DW-1:0]      out_data,
  output logic [IDW-1:0]        out_id
`ifdef SHARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NREQ*8-1:0]     grant_cnt
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SH_DW-1:0]   r_data;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [RR_MAXN-1:0] w_valid8;
  logic [RR_IW-1:0]   w_ptr3;
  rr_pick_t           w_pick;
  logic               w_can_accept;
  logic               w_accept;
  logic [SH_DW-1:0]   w_mux_dat;
  logic [SH_AW-1:0]   w_mux_amt;
  logic [SH_DW-1:0]   w_shift_out;

  assign w_valid8     = RR_MAXN'(req_valid);
  assign w_ptr3       = RR_IW'(r_rr_ptr);
  assign w_pick       = rr_pick(w_valid8, w_ptr3, NREQ);
  assign w_can_accept = (r_state == IDLE) || out_ready;
  assign w_accept     = w_pick.found && w_can_accept;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept && (w_pick.idx == RR_IW'(i))) req_ready[i] = 1'b1;
    end
  end

  assign w_mux_dat = req_data[int'(w_pick.idx)*SH_DW +: SH_DW];
  assign w_mux_amt = req_amt[int'(w_pick.idx)*SH_AW +: SH_AW];

  barrel_leftshifter_16bit u_shifter (
    .in   (w_mux_dat),
    .ctrl (w_mux_amt),
    .out  (w_shift_out)
  );

  assign w_ptr_nxt = (w_pick.idx == RR_IW'(NREQ - 1)) ? '0 : IDW'(w_pick.idx + 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = FULL;
      FULL:    if (!w_accept && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data   <= w_shift_out;
        r_id     <= IDW'(w_pick.idx);
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_id    = r_id;

`ifdef SHARB_STATS_EN
  logic [NREQ-1:0][7:0] r_grant_cnt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    // Clear wins over increment; counter sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_grant_cnt[gi] <= 8'd0;
      end else if (stats_clr) begin
        r_grant_cnt[gi] <= 8'd0;
      end else if (req_ready[gi] && req_valid[gi] && (r_grant_cnt[gi] != 8'hFF)) begin
        r_grant_cnt[gi] <= r_grant_cnt[gi] + 8'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter (NREQ=4); define SHARB_STATS_EN to exercise grant counters.
module tb_shifter_arbiter;

  localparam int NREQ = 4;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [63:0]     req_data;
  logic [15:0]     req_amt;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic [1:0]      out_id;
`ifdef SHARB_STATS_EN
  logic            stats_clr;
  logic [31:0]     grant_cnt;
`endif

  int n_checks;
  int n_fail;

  shifter_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef SHARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one request at a negedge, samples ready before the edge and the result after it.
  task automatic send_one(input int idx, input logic [15:0] d, input logic [3:0] a,
                          output logic [3:0] rdy, output logic vld,
                          output logic [15:0] od, output logic [1:0] oid);
    @(negedge clk);
    req_data[16*idx +: 16] = d;
    req_amt[4*idx +: 4]    = a;
    req_valid              = 4'(1 << idx);
    out_ready              = 1'b1;
    #1 rdy = req_ready;
    @(posedge clk);
    #1;
    req_valid = '0;
    vld = out_valid;
    od  = out_data;
    oid = out_id;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    out_ready = 1'b0;
`ifdef SHARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] rdy; logic vld; logic [15:0] od; logic [1:0] oid;
    send_one(0, 16'd10, 4'd1, rdy, vld, od, oid);
    n_checks++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", rdy); end
    n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", vld); end
    n_checks++; if (od !== 16'd20) begin n_fail++; $display("FAIL single_data got %h want 0014", od); end
    n_checks++; if (oid !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d want 0", oid); end
    send_one(0, 16'h0800, 4'd8, rdy, vld, od, oid);
    n_checks++; if (od !== 16'h0000) begin n_fail++; $display("FAIL single_overflow got %h want 0000", od); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_pass_max();
    logic [3:0] rdy; logic vld; logic [15:0] od; logic [1:0] oid;
    send_one(2, 16'hA5A5, 4'd0, rdy, vld, od, oid);
    n_checks++; if (od !== 16'hA5A5) begin n_fail++; $display("FAIL pass_data got %h want a5a5", od); end
    n_checks++; if (oid !== 2'd2) begin n_fail++; $display("FAIL pass_id got %0d want 2", oid); end
    send_one(3, 16'h0001, 4'd15, rdy, vld, od, oid);
    n_checks++; if (rdy !== 4'b1000) begin n_fail++; $display("FAIL max_ready got %b want 1000", rdy); end
    n_checks++; if (od !== 16'h8000) begin n_fail++; $display("FAIL max_data got %h want 8000", od); end
    n_checks++; if (oid !== 2'd3) begin n_fail++; $display("FAIL max_id got %0d want 3", oid); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_data[16*i +: 16] = 16'(i + 1);
      req_amt[4*i +: 4]    = 4'(i);
    end
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      exp_d = 16'((k % 4 + 1) << (k % 4));
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", k, out_valid); end
      n_checks++; if (out_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", k, out_id, k % 4); end
      n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", k, out_data, exp_d); end
      n_checks++; if (req_ready !== 4'(1 << ((k + 1) % 4))) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'(1 << ((k + 1) % 4))); end
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_data[15:0]  = 16'h0003;
    req_amt[3:0]    = 4'd2;
    req_valid       = 4'b0001;
    out_ready       = 1'b0;
    @(posedge clk); #1;
    req_data[31:16] = 16'h0101;
    req_amt[7:4]    = 4'd4;
    req_valid       = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", k, req_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", k, out_valid); end
      n_checks++; if (out_data !== 16'h000C) begin n_fail++; $display("FAIL bp_data[%0d] got %h want 000c", k, out_data); end
      n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL bp_id[%0d] got %0d want 0", k, out_id); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got %b want 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 16'h1010) begin n_fail++; $display("FAIL bp_next_data got %h want 1010", out_data); end
    n_checks++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL bp_next_id got %0d want 1", out_id); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_data[47:32] = 16'h1234;
    req_amt[11:8]   = 4'd4;
    req_valid       = 4'b0100;
    out_ready       = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_held got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL ar_data got %h want 0000", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_no_replay got %b want 0", out_valid); end
  endtask

`ifdef SHARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    @(negedge clk);
    req_data[47:32] = 16'h0001;
    req_amt[11:8]   = 4'd1;
    req_valid       = 4'b0100;
    out_ready       = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (grant_cnt[23:16] !== 8'd10) begin n_fail++; $display("FAIL stats_count got %0d want 10", grant_cnt[23:16]); end
    repeat (290) @(posedge clk);
    #1;
    n_checks++; if (grant_cnt[23:16] !== 8'd255) begin n_fail++; $display("FAIL stats_sat got %0d want 255", grant_cnt[23:16]); end
    n_checks++; if (grant_cnt[7:0] !== 8'd0) begin n_fail++; $display("FAIL stats_other got %0d want 0", grant_cnt[7:0]); end
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    req_valid = '0;
    n_checks++; if (grant_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_clr got %h want 0", grant_cnt); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_pass_max();
    test_round_robin();
    test_backpressure();
    test_async_reset();
`ifdef SHARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
